// File: rtl/trig_counter_snap.sv
// Trigger-driven 32-bit up/down counter with a free-run prescaler and a coherent
// two-word snapshot for tear-free host readout; event pulses feed a TriggerOut.
module trig_counter_snap #(
  parameter int PRESCALE_W = 16,
  parameter int LED_LSB    = 23
) (
  input  logic                  clk1,
  input  logic                  reset_n,
  input  logic [15:0]           ep_trigger,
  input  logic [15:0]           load_lo,
  input  logic [15:0]           load_hi,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  direction,
  input  logic                  halt_on_term,
  input  logic [31:0]           terminal,
  output logic [31:0]           count,
  output logic [15:0]           snap_lo,
  output logic [15:0]           snap_hi,
  output logic                  snap_valid,
  output logic                  running,
  output logic [15:0]           event_trig,
  output logic [3:0]            led,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                state_q, state_next;
  logic [PRESCALE_W-1:0] pres_q, pres_next;
  logic [31:0]           count_next;
  logic [31:0]           snapshot_q;
  logic                  step_up, step_dn, tick, wrap, term_hit;

  logic trg_clear, trg_up, trg_down, trg_load, trg_snap, trg_start, trg_stop;
  assign trg_clear = ep_trigger[0];
  assign trg_up    = ep_trigger[1];
  assign trg_down  = ep_trigger[2];
  assign trg_load  = ep_trigger[3];
  assign trg_snap  = ep_trigger[4];
  assign trg_start = ep_trigger[5];
  assign trg_stop  = ep_trigger[6];

  logic unused_trig;
  assign unused_trig = ^ep_trigger[15:7];

  assign tick = (state_q == RUN) && (pres_q >= prescale);

  // One count action per cycle; any manual trigger (even up+down cancelling) swallows a tick.
  always_comb begin
    step_up    = 1'b0;
    step_dn    = 1'b0;
    count_next = count;
    if (trg_clear) begin
      count_next = 32'd0;
    end else if (trg_load) begin
      count_next = {load_hi, load_lo};
    end else if (trg_up ^ trg_down) begin
      step_up = trg_up;
      step_dn = trg_down;
    end else if (!trg_up && !trg_down && tick) begin
      step_up = ~direction;
      step_dn = direction;
    end
    if (step_up) begin
      count_next = count + 32'd1;
    end else if (step_dn) begin
      count_next = count - 32'd1;
    end
    wrap     = (step_up && (count == 32'hFFFF_FFFF)) || (step_dn && (count == 32'd0));
    term_hit = (count_next == terminal) && (count_next != count);
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: if (!trg_stop && trg_start) state_next = RUN;
      RUN: begin
        if (trg_stop)                      state_next = IDLE;
        else if (term_hit && halt_on_term) state_next = HALT;
      end
      HALT: begin
        if (trg_stop || trg_clear) state_next = IDLE;
        else if (trg_start)        state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Prescaler only advances while staying in RUN; it restarts from 0 on entry and on clear.
  always_comb begin
    pres_next = '0;
    if ((state_q == RUN) && (state_next == RUN) && !trg_clear && !tick) begin
      pres_next = pres_q + 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pres_q     <= '0;
      count      <= 32'd0;
      snapshot_q <= 32'd0;
      snap_valid <= 1'b0;
      event_trig <= 16'd0;
    end else begin
      state_q    <= state_next;
      pres_q     <= pres_next;
      count      <= count_next;
      event_trig <= {13'd0, trg_snap, term_hit, wrap};
      if (trg_snap) begin
        snapshot_q <= count;
        snap_valid <= 1'b1;
      end
    end
  end

  assign snap_lo   = snapshot_q[15:0];
  assign snap_hi   = snapshot_q[31:16];
  assign running   = (state_q == RUN);
  assign led       = ~count[LED_LSB+3:LED_LSB];
  assign fsm_state = state_q;

endmodule
